cpu6_pipeline_drain: RTL and testbench
======================================

CPU6_PIPELINE_DRAIN -- requirements
Module: cpu6_pipeline_drain

Interface
REQ-001 Parameter TIMEOUT_W, default 8, width of the drain cycle counter.
REQ-002 Parameter TIMEOUT, default 255, maximum DRAIN cycles before abort; legal range 1..2^TIMEOUT_W-1.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 empty_pipeline_reqE  input  1  instruction in EX requests an empty pipeline (registered ID/EX field).
REQ-006 flash  input  1  pipeline flush (redirect/exception) this cycle.
REQ-007 validM  input  1  MEM stage holds a valid instruction.
REQ-008 validW  input  1  WB stage holds a valid instruction.
REQ-009 mem_busy  input  1  data-memory transaction outstanding.
REQ-010 stall_fde  output  1  hold PC, IF/ID and ID/EX registers.
REQ-011 bubble_m  output  1  load a bubble into EX/MEM.
REQ-012 drain_busy  output  1  FSM in DRAIN.
REQ-013 drain_done  output  1  one-cycle pulse: pipeline empty, EX instruction released.
REQ-014 drain_err  output  1  one-cycle pulse: drain aborted by timeout.

Function
REQ-015 FSM states SHALL be IDLE, DRAIN, DONE, ERR, held in a 2-bit registered state.
REQ-016 "empty" SHALL mean ~validM & ~validW & ~mem_busy.
REQ-017 IDLE: empty_pipeline_reqE & ~flash -> DRAIN, counter cleared to 0; otherwise stay IDLE.
REQ-018 DRAIN priority, highest first: flash -> IDLE; empty -> DONE; counter == TIMEOUT-1 -> ERR; else stay DRAIN, counter +1.
REQ-019 DONE and ERR SHALL each last exactly one cycle and return to IDLE unconditionally.
REQ-020 stall_fde SHALL be combinational: ~flash & ((IDLE & empty_pipeline_reqE) | DRAIN).
REQ-021 bubble_m SHALL equal stall_fde.
REQ-022 drain_busy SHALL be 1 iff state == DRAIN.
REQ-023 drain_done SHALL be 1 iff state == DONE; drain_err 1 iff state == ERR; stall_fde SHALL be 0 in both, so the EX instruction advances that cycle.
REQ-024 Minimum stall: request seen in IDLE at cycle N with pipeline already empty -> stall in N and N+1, drain_done in N+2.
REQ-025 Request still asserted in DONE/ERR SHALL be ignored (instruction leaves EX that cycle); a request in the following IDLE cycle is a new drain.
REQ-026 Counter SHALL be TIMEOUT_W bits, never wrap, increment only in DRAIN.
REQ-027 flash in DRAIN SHALL produce neither drain_done nor drain_err; flash in DONE/ERR SHALL not suppress the pulse.
REQ-028 validM/validW/mem_busy SHALL be sampled every DRAIN cycle; no latching of earlier values.

Reset
REQ-029 reset SHALL asynchronously force state IDLE and counter 0.
REQ-030 During and after reset until the first request: stall_fde=0 (with req=0), bubble_m=0, drain_busy=0, drain_done=0, drain_err=0.
REQ-031 reset asserted mid-DRAIN SHALL abandon the drain with no done/err pulse.

Verification
REQ-032 Empty pipeline, req=1 cycle 0 -> stall_fde=1 cycles 0-1, drain_busy=1 cycle 1, drain_done=1 cycle 2, stall_fde=0 cycle 2.
REQ-033 req cycle 0, validM=1 cycles 0-2, validW=1 cycles 0-3, mem_busy=1 cycles 0-4 -> DRAIN cycles 1-5, drain_done cycle 6.
REQ-034 req cycle 0, mem_busy held 1, TIMEOUT=4 -> DRAIN cycles 1-4, drain_err cycle 5, no drain_done, stall_fde=0 cycle 5.
REQ-035 req cycle 0, validM=1 held, flash=1 cycle 3 -> stall_fde=0 cycle 3, IDLE cycle 4, no drain_done/drain_err.
REQ-036 reset pulse mid-DRAIN (cycle 2) -> all outputs 0 immediately, IDLE after release, no pulses; req=1 with flash=1 in IDLE -> stall_fde=0, stays IDLE.
REQ-037 req held 1 across DONE and next cycle -> second drain starts in the IDLE cycle after DONE, second drain_done after its own minimum latency.

Source files
------------

// File: rtl/cpu6_pipeline_drain.sv
// ---------------------------------------------------------------------------
// cpu6_pipeline_drain
//
// Holds the front end of the CPU6 pipeline while the instruction in EX waits
// for MEM, WB and the data-memory port to go quiet. That is how serializing
// instructions (fences, CSR writes with side effects, and similar) get an
// empty machine before they retire. The wait is bounded: if the pipeline
// does not empty within TIMEOUT cycles, the drain is abandoned and drain_err
// pulses.
//
// FSM: IDLE -> DRAIN -> DONE/ERR -> IDLE. DONE and ERR each last one cycle.
// In those cycles the stall is released, so the EX instruction moves on.
//
// Parameters
//   TIMEOUT_W  width of the drain cycle counter
//   TIMEOUT    DRAIN cycles allowed before abort, 1 .. 2**TIMEOUT_W-1
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous active-high reset
//   empty_pipeline_reqE  EX instruction wants an empty pipeline (ID/EX field)
//   flash                pipeline flush (redirect/exception) this cycle
//   validM / validW      MEM / WB stage occupancy
//   mem_busy             data-memory transaction outstanding
//   stall_fde            hold PC, IF/ID and ID/EX (combinational)
//   bubble_m             load a bubble into EX/MEM (same as stall_fde)
//   drain_busy           FSM is in DRAIN
//   drain_done           one-cycle pulse: pipeline empty, EX released
//   drain_err            one-cycle pulse: drain aborted by timeout
// ---------------------------------------------------------------------------
module cpu6_pipeline_drain #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic empty_pipeline_reqE,
  input  logic flash,
  input  logic validM,
  input  logic validW,
  input  logic mem_busy,
  output logic stall_fde,
  output logic bubble_m,
  output logic drain_busy,
  output logic drain_done,
  output logic drain_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Value the counter holds in the last DRAIN cycle that is allowed.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 pipe_empty;
  logic                 cnt_expired;

  // Sampled live every cycle. Nothing earlier is remembered, so a stage that
  // refills during the drain keeps the drain going.
  assign pipe_empty  = ~validM & ~validW & ~mem_busy;
  assign cnt_expired = (cnt == CNT_LAST);

  // The stall must take effect in the same cycle the request first shows up
  // in EX, so it is decoded from the live request and cannot be registered.
  // A flush overrides it: the flushed instruction must not be held.
  assign stall_fde = ~flash & (((state == IDLE) & empty_pipeline_reqE) |
                               (state == DRAIN));
  assign bubble_m  = stall_fde;

  // Status outputs are registered alongside the state. They are
  // glitch-free and are 1 exactly when the state is DRAIN, DONE or ERR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      drain_busy <= 1'b0;
      drain_done <= 1'b0;
      drain_err  <= 1'b0;
    end else begin
      drain_busy <= 1'b0;
      drain_done <= 1'b0;
      drain_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (empty_pipeline_reqE & ~flash) begin
            state      <= DRAIN;
            cnt        <= '0;
            drain_busy <= 1'b1;
          end
        end
        DRAIN: begin
          // A flush beats everything. It ends the drain with no pulse, because
          // the instruction that asked for the drain no longer exists.
          if (flash) begin
            state <= IDLE;
          end else if (pipe_empty) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end else if (cnt_expired) begin
            state     <= ERR;
            drain_err <= 1'b1;
          end else begin
            drain_busy <= 1'b1;
            // The state leaves DRAIN before the counter can reach all-ones.
            // This guard only makes "never wraps" true even for a parameter
            // value that is out of range.
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        // One-cycle pulses. A request still present here belongs to the
        // instruction now leaving EX, so it is ignored. A flush has nothing
        // left to cancel.
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_pipeline_drain.sv
// Scoreboard bench for cpu6_pipeline_drain. Two instances share the same
// stimulus: A uses the default TIMEOUT (255) and B uses TIMEOUT=4, so one
// vector list covers both the normal drains and the timeout path. Every
// vector pushes the hand-computed expected outputs of that cycle, one entry
// per DUT. The monitor pops and compares on the falling edge.
// Output word layout: {stall_fde, bubble_m, drain_busy, drain_done, drain_err}
module tb_cpu6_pipeline_drain;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0, flash = 1'b0, validM = 1'b0, validW = 1'b0, mem_busy = 1'b0;

  logic stall_a, bubble_a, busy_a, done_a, err_a;
  logic stall_b, bubble_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  cpu6_pipeline_drain u_dut_a (
    .clk(clk), .reset(reset), .empty_pipeline_reqE(req), .flash(flash),
    .validM(validM), .validW(validW), .mem_busy(mem_busy),
    .stall_fde(stall_a), .bubble_m(bubble_a), .drain_busy(busy_a),
    .drain_done(done_a), .drain_err(err_a)
  );

  cpu6_pipeline_drain #(.TIMEOUT_W(8), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .reset(reset), .empty_pipeline_reqE(req), .flash(flash),
    .validM(validM), .validW(validW), .mem_busy(mem_busy),
    .stall_fde(stall_b), .bubble_m(bubble_b), .drain_busy(busy_b),
    .drain_done(done_b), .drain_err(err_b)
  );

  // Expected output words
  localparam logic [4:0] Z = 5'b00000;  // idle, no stall
  localparam logic [4:0] S = 5'b11000;  // IDLE with request: stall
  localparam logic [4:0] D = 5'b11100;  // DRAIN, stalling
  localparam logic [4:0] F = 5'b00100;  // DRAIN with flash: stall dropped
  localparam logic [4:0] N = 5'b00010;  // DONE pulse
  localparam logic [4:0] E = 5'b00001;  // ERR pulse

  typedef struct {
    logic [4:0] exp;
    string      name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;

  // Drive one cycle of inputs just after the rising edge. Queue what each
  // DUT must show in that cycle.
  task automatic v(input string nm, input logic r, input logic rq, input logic fl,
                   input logic vm, input logic vw, input logic mb,
                   input logic [4:0] ea, input logic [4:0] eb);
    @(posedge clk);
    #1;
    reset = r; req = rq; flash = fl; validM = vm; validW = vw; mem_busy = mb;
    qa.push_back('{exp: ea, name: nm});
    qb.push_back('{exp: eb, name: nm});
  endtask

  // Monitor: independent of the driver. It compares whatever the DUTs
  // present in the middle of each cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] act;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      act = {stall_a, bubble_a, busy_a, done_a, err_a};
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s dutA got %b expected %b", e.name, act, e.exp);
      end
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      act = {stall_b, bubble_b, busy_b, done_b, err_b};
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s dutB got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  initial begin
    //  name         rst req fl vM vW mb  A  B
    // reset state
    v("rst0",        1, 0, 0, 0, 0, 0, Z, Z);
    v("rst1",        1, 0, 0, 1, 1, 1, Z, Z);
    v("idle",        0, 0, 0, 0, 0, 0, Z, Z);

    // minimum latency on an empty pipeline
    v("min_c0",      0, 1, 0, 0, 0, 0, S, S);
    v("min_c1",      0, 0, 0, 0, 0, 0, D, D);
    v("min_c2",      0, 0, 0, 0, 0, 0, N, N);
    v("min_c3",      0, 0, 0, 0, 0, 0, Z, Z);

    // staggered emptying: A finishes, B (TIMEOUT=4) times out first
    v("stag_c0",     0, 1, 0, 1, 1, 1, S, S);
    v("stag_c1",     0, 0, 0, 1, 1, 1, D, D);
    v("stag_c2",     0, 0, 0, 1, 1, 1, D, D);
    v("stag_c3",     0, 0, 0, 0, 1, 1, D, D);
    v("stag_c4",     0, 0, 0, 0, 0, 1, D, D);
    v("stag_c5",     0, 0, 0, 0, 0, 0, D, E);
    v("stag_c6",     0, 0, 0, 0, 0, 0, N, Z);
    v("stag_c7",     0, 0, 0, 0, 0, 0, Z, Z);

    // mem_busy stuck: B times out at cycle 5, A keeps draining
    v("tmo_c0",      0, 1, 0, 0, 0, 1, S, S);
    v("tmo_c1",      0, 0, 0, 0, 0, 1, D, D);
    v("tmo_c2",      0, 0, 0, 0, 0, 1, D, D);
    v("tmo_c3",      0, 0, 0, 0, 0, 1, D, D);
    v("tmo_c4",      0, 0, 0, 0, 0, 1, D, D);
    v("tmo_c5",      0, 0, 0, 0, 0, 1, D, E);
    v("tmo_c6",      0, 0, 0, 0, 0, 1, D, Z);
    v("tmo_c7",      0, 0, 0, 0, 0, 0, D, Z);
    v("tmo_c8",      0, 0, 0, 0, 0, 0, N, Z);
    v("tmo_c9",      0, 0, 0, 0, 0, 0, Z, Z);

    // flush mid-drain: no pulse on either DUT
    v("fl_c0",       0, 1, 0, 1, 0, 0, S, S);
    v("fl_c1",       0, 0, 0, 1, 0, 0, D, D);
    v("fl_c2",       0, 0, 0, 1, 0, 0, D, D);
    v("fl_c3",       0, 0, 1, 1, 0, 0, F, F);
    v("fl_c4",       0, 0, 0, 1, 0, 0, Z, Z);
    v("fl_c5",       0, 0, 0, 0, 0, 0, Z, Z);

    // reset mid-drain, then request blocked by flash in IDLE
    v("rd_c0",       0, 1, 0, 1, 0, 0, S, S);
    v("rd_c1",       0, 0, 0, 1, 0, 0, D, D);
    v("rd_c2",       1, 0, 0, 1, 0, 0, Z, Z);
    v("rd_c3",       0, 0, 0, 1, 0, 0, Z, Z);
    v("rd_c4",       0, 0, 0, 0, 0, 0, Z, Z);
    v("rqfl_c0",     0, 1, 1, 0, 0, 0, Z, Z);
    v("rqfl_c1",     0, 0, 0, 0, 0, 0, Z, Z);

    // request held across DONE starts a second drain in the next IDLE cycle
    v("held_c0",     0, 1, 0, 0, 0, 0, S, S);
    v("held_c1",     0, 1, 0, 0, 0, 0, D, D);
    v("held_c2",     0, 1, 0, 0, 0, 0, N, N);
    v("held_c3",     0, 1, 0, 0, 0, 0, S, S);
    v("held_c4",     0, 1, 0, 0, 0, 0, D, D);
    v("held_c5",     0, 0, 0, 0, 0, 0, N, N);
    v("held_c6",     0, 0, 0, 0, 0, 0, Z, Z);

    // flash during DONE does not suppress the pulse
    v("fdone_c0",    0, 1, 0, 0, 0, 0, S, S);
    v("fdone_c1",    0, 0, 0, 0, 0, 0, D, D);
    v("fdone_c2",    0, 0, 1, 0, 0, 0, N, N);
    v("fdone_c3",    0, 0, 0, 0, 0, 0, Z, Z);

    // flash during ERR (B) does not suppress the pulse; A is flushed out
    v("ferr_c0",     0, 1, 0, 0, 0, 1, S, S);
    v("ferr_c1",     0, 0, 0, 0, 0, 1, D, D);
    v("ferr_c2",     0, 0, 0, 0, 0, 1, D, D);
    v("ferr_c3",     0, 0, 0, 0, 0, 1, D, D);
    v("ferr_c4",     0, 0, 0, 0, 0, 1, D, D);
    v("ferr_c5",     0, 0, 1, 0, 0, 1, F, E);
    v("ferr_c6",     0, 0, 0, 0, 0, 0, Z, Z);

    // let the monitor consume the last entries
    repeat (2) @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain_queue left A=%0d B=%0d expected 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
